// File: rtl/bpu_lpht_pkg.sv
// ============================================================================
// bpu_lpht_pkg : shared LPHT constants and 2-bit counter helpers
// Revision     : 1.0
// ============================================================================
`default_nettype none

`ifndef _LPHT_ADDR_WIDTH
`define _LPHT_ADDR_WIDTH 10
`endif

package bpu_lpht_pkg;

  localparam int         LPHT_ADDR_WIDTH = `_LPHT_ADDR_WIDTH;
  localparam logic [1:0] LPHT_INIT_VALUE = 2'b01;

  typedef logic [1:0] lphr_t;

  function automatic lphr_t lphr_sat_inc(input lphr_t v);
    return (v == 2'b11) ? v : v + 2'b01;
  endfunction

  function automatic lphr_t lphr_sat_dec(input lphr_t v);
    return (v == 2'b00) ? v : v - 2'b01;
  endfunction

  // Next counter value comes only from the snapshot carried with the prediction.
  function automatic lphr_t lphr_next(input lphr_t v, input logic taken);
    return taken ? lphr_sat_inc(v) : lphr_sat_dec(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bpu_lpht_ram.sv
// ============================================================================
// bpu_lpht_ram : simple dual-port RAM, one write port, one synchronous read
// Revision     : 1.0
// ============================================================================
`default_nettype none

module bpu_lpht_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Read-before-write on an address collision; the top bypasses around it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/bpu_lpht.sv
// ============================================================================
// bpu_lpht : local pattern history table with init sweep, staged update and
//            read bypass. Optional statistics counters: BPU_LPHT_STAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bpu_lpht
  import bpu_lpht_pkg::*;
#(
  parameter int         ADDR_WIDTH = LPHT_ADDR_WIDTH,
  parameter logic [1:0] INIT_VALUE = LPHT_INIT_VALUE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pred_req_i,
  input  logic [ADDR_WIDTH-1:0] pred_index_i,
  output logic                  pred_valid_o,
  output logic [1:0]            pred_lphr_o,
  output logic                  pred_taken_o,
  input  logic                  upd_valid_i,
  input  logic [ADDR_WIDTH-1:0] upd_index_i,
  input  logic [1:0]            upd_lphr_i,
  input  logic                  upd_taken_i,
  output logic                  init_done_o,
  output logic [31:0]           stat_upd_cnt_o,
  output logic [31:0]           stat_flip_cnt_o
);

  localparam logic [0:0]            ST_INIT  = 1'b0;
  localparam logic [0:0]            ST_RUN   = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_init_done;

  logic                  r_stg_valid;
  logic [ADDR_WIDTH-1:0] r_stg_index;
  logic [1:0]            r_stg_lphr;

  logic                  r_pred_valid;
  logic                  r_sel_init;
  logic                  r_sel_byp;
  logic [1:0]            r_byp_lphr;

  logic                  w_run;
  logic                  w_upd_accept;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [1:0]            w_wr_data;
  logic [1:0]            w_ram_rdata;

  assign w_run        = (r_state == ST_RUN);
  assign w_upd_accept = upd_valid_i && w_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_ptr       <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_ptr <= r_ptr + PTR_ONE;
      if (r_ptr == PTR_LAST) begin
        r_state     <= ST_RUN;
        r_init_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_valid <= 1'b0;
      r_stg_index <= '0;
      r_stg_lphr  <= 2'b00;
    end else begin
      r_stg_valid <= w_upd_accept;
      if (w_upd_accept) begin
        r_stg_index <= upd_index_i;
        r_stg_lphr  <= lphr_next(upd_lphr_i, upd_taken_i);
      end
    end
  end

  // The init sweep owns the write port until RUN; afterwards the stage register does.
  assign w_wr_en   = w_run ? r_stg_valid : 1'b1;
  assign w_wr_addr = w_run ? r_stg_index : r_ptr;
  assign w_wr_data = w_run ? r_stg_lphr  : INIT_VALUE;

  bpu_lpht_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (w_wr_addr),
    .wr_data (w_wr_data),
    .rd_en   (pred_req_i),
    .rd_addr (pred_index_i),
    .rd_data (w_ram_rdata)
  );

  // Output selects only move on a request, so the data outputs hold between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_sel_init   <= 1'b1;
      r_sel_byp    <= 1'b0;
      r_byp_lphr   <= INIT_VALUE;
    end else begin
      r_pred_valid <= pred_req_i;
      if (pred_req_i) begin
        r_sel_init <= !w_run;
        r_sel_byp  <= r_stg_valid && (r_stg_index == pred_index_i);
        r_byp_lphr <= r_stg_lphr;
      end
    end
  end

  assign pred_valid_o = r_pred_valid;
  assign pred_lphr_o  = r_sel_init ? INIT_VALUE :
                        (r_sel_byp ? r_byp_lphr : w_ram_rdata);
  assign pred_taken_o = pred_lphr_o[1];
  assign init_done_o  = r_init_done;

`ifdef BPU_LPHT_STAT_EN
  logic [31:0] r_stat_upd;
  logic [31:0] r_stat_flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_upd  <= 32'd0;
      r_stat_flip <= 32'd0;
    end else if (w_upd_accept) begin
      if (r_stat_upd != 32'hFFFF_FFFF) begin
        r_stat_upd <= r_stat_upd + 32'd1;
      end
      if ((upd_lphr_i[1] != upd_taken_i) && (r_stat_flip != 32'hFFFF_FFFF)) begin
        r_stat_flip <= r_stat_flip + 32'd1;
      end
    end
  end

  assign stat_upd_cnt_o  = r_stat_upd;
  assign stat_flip_cnt_o = r_stat_flip;
`else
  assign stat_upd_cnt_o  = 32'd0;
  assign stat_flip_cnt_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bpu_lpht.sv
// ============================================================================
// tb_bpu_lpht : randomized self-checking bench for bpu_lpht (ADDR_WIDTH=4)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bpu_lpht;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pred_req = 1'b0;
  logic [AW-1:0] pred_index = '0;
  logic          pred_valid;
  logic [1:0]    pred_lphr;
  logic          pred_taken;
  logic          upd_valid = 1'b0;
  logic [AW-1:0] upd_index = '0;
  logic [1:0]    upd_lphr = 2'b00;
  logic          upd_taken = 1'b0;
  logic          init_done;
  logic [31:0]   stat_upd_cnt;
  logic [31:0]   stat_flip_cnt;

  bpu_lpht #(
    .ADDR_WIDTH (AW),
    .INIT_VALUE (2'b01)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pred_req_i      (pred_req),
    .pred_index_i    (pred_index),
    .pred_valid_o    (pred_valid),
    .pred_lphr_o     (pred_lphr),
    .pred_taken_o    (pred_taken),
    .upd_valid_i     (upd_valid),
    .upd_index_i     (upd_index),
    .upd_lphr_i      (upd_lphr),
    .upd_taken_i     (upd_taken),
    .init_done_o     (init_done),
    .stat_upd_cnt_o  (stat_upd_cnt),
    .stat_flip_cnt_o (stat_flip_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: table contents as seen by reads, cycles since reset release,
  // last read value presented and expected statistics.
  int          tab [DEPTH];
  int          cyc;
  int          exp_lphr;
  int unsigned exp_upd;
  int unsigned exp_flip;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_next(input int v, input bit taken);
    if (taken) return (v < 3) ? v + 1 : 3;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) tab[i] = 1;
    cyc      = 0;
    exp_lphr = 1;
    exp_upd  = 0;
    exp_flip = 0;
  endtask

  task automatic drive(input bit req, input int idx, input bit uv, input int ui,
                       input int ul, input bit ut);
    pred_req   = req;
    pred_index = idx[AW-1:0];
    upd_valid  = uv;
    upd_index  = ui[AW-1:0];
    upd_lphr   = ul[1:0];
    upd_taken  = ut;
  endtask

  task automatic drive_rand();
    int idx;
    int ui;
    idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH-1);
    ui  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH-1);
    drive($urandom_range(0, 1), idx, $urandom_range(0, 1), ui,
          $urandom_range(0, 3), $urandom_range(0, 1));
  endtask

  // One clock: the model absorbs this cycle's inputs, then outputs are checked.
  task automatic step();
    bit in_init;
    bit req;
    int idx;
    bit uv;
    int ui;
    int ul;
    bit ut;
    in_init = (cyc < DEPTH);
    req = pred_req;  idx = pred_index;
    uv  = upd_valid; ui  = upd_index; ul = upd_lphr; ut = upd_taken;
    @(posedge clk);
    #1;
    if (req) exp_lphr = in_init ? 1 : tab[idx];
    if (!in_init && uv) begin
      tab[ui] = sat_next(ul, ut);
      if (exp_upd != 32'hFFFF_FFFF) exp_upd++;
      if ((ul >= 2) != ut && exp_flip != 32'hFFFF_FFFF) exp_flip++;
    end
    cyc++;
    check_eq("pred_valid", pred_valid, req);
    check_eq("pred_lphr", pred_lphr, exp_lphr);
    check_eq("pred_taken", pred_taken, exp_lphr >= 2);
    check_eq("init_done", init_done, cyc >= DEPTH);
`ifdef BPU_LPHT_STAT_EN
    check_eq("stat_upd", stat_upd_cnt, exp_upd);
    check_eq("stat_flip", stat_flip_cnt, exp_flip);
`else
    check_eq("stat_upd_tied", stat_upd_cnt, 32'd0);
    check_eq("stat_flip_tied", stat_flip_cnt, 32'd0);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, pred_valid, 1'b0);
    check_eq({tag, "_lphr"}, pred_lphr, 2'b01);
    check_eq({tag, "_taken"}, pred_taken, 1'b0);
    check_eq({tag, "_init_done"}, init_done, 1'b0);
    check_eq({tag, "_stat_upd"}, stat_upd_cnt, 32'd0);
    check_eq({tag, "_stat_flip"}, stat_flip_cnt, 32'd0);
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    // INIT: reads forced to INIT_VALUE, the update to index 3 must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 4) drive(1, i, 1, 3, 3, 1);
      else        drive(1, i, 0, 0, 0, 0);
      step();
      if (i == DEPTH-2) check_eq("init_not_yet", init_done, 1'b0);
    end
    check_eq("init_done_at_16", init_done, 1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      drive(1, i, 0, 0, 0, 0);
      step();
      if (i > 0) check_eq("sweep_init_value", pred_lphr, 2'b01);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    check_eq("sweep_last", pred_lphr, 2'b01);

    // Bypass: update idx 5 then read it on the next cycle.
    drive(0, 0, 1, 5, 3, 1); step();
    drive(1, 5, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    check_eq("bypass_sat3", pred_lphr, 2'd3);
    drive(0, 0, 1, 5, 0, 0); step();
    drive(1, 5, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    check_eq("flush_to_0", pred_lphr, 2'd0);

    // Same-cycle read of an updated index sees the old value.
    drive(1, 7, 1, 7, 1, 1); step();
    check_eq("same_cycle_old", pred_lphr, 2'd1);
    drive(1, 7, 0, 0, 0, 0); step();
    check_eq("next_cycle_new", pred_lphr, 2'd2);

    // Back-to-back updates to idx 9: last write wins.
    drive(0, 0, 1, 9, 1, 1); step();
    drive(0, 0, 1, 9, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(1, 9, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    check_eq("b2b_last_wins", pred_lphr, 2'd0);

    for (int n = 0; n < 400; n++) begin
      drive_rand();
      step();
    end

    // Asynchronous reset in the middle of traffic.
    drive(1, 2, 1, 2, 3, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    model_reset();
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_rand();
      step();
    end

    // Three updates, one of them a direction flip (lphr=2, not taken).
    drive(0, 0, 1, 1, 3, 1); step();
    drive(0, 0, 1, 2, 2, 0); step();
    drive(0, 0, 1, 3, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
`ifdef BPU_LPHT_STAT_EN
    check_eq("stat_upd_3", stat_upd_cnt, 32'd3);
    check_eq("stat_flip_1", stat_flip_cnt, 32'd1);
`endif

    for (int n = 0; n < 200; n++) begin
      drive_rand();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
